// File: rtl/deserializer_pkg.sv
// Shared types and helpers for the sample deserializer.
package deserializer_pkg;

    typedef enum logic {
        RECV = 1'b0,
        SEND = 1'b1
    } state_e;

    // Slot index width; a one-slot frame still carries a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/deserializer_SlotArray.sv
// N_SAMPLES x BIT_WIDTH register bank; one slot is written per cycle at wr_idx when wr_en is high.
// Write data is visible on slot_dat the cycle after the write; no backpressure of its own.
module deserializer_SlotArray #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8,
    parameter int CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [CNT_W-1:0]     wr_idx,
    input  logic [BIT_WIDTH-1:0] wr_dat,
    output logic [BIT_WIDTH-1:0] slot_dat [N_SAMPLES-1:0]
);

    logic [BIT_WIDTH-1:0] slot_q [N_SAMPLES-1:0];
    logic [BIT_WIDTH-1:0] slot_d [N_SAMPLES-1:0];

    always_comb begin
        for (int i = 0; i < N_SAMPLES; i++) begin
            slot_d[i] = slot_q[i];
            if (wr_en && (wr_idx == CNT_W'(i))) begin
                slot_d[i] = wr_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SAMPLES; i++) begin
            if (reset) begin
                slot_q[i] <= '0;
            end else begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SAMPLES; i++) begin
            slot_dat[i] = slot_q[i];
        end
    end

endmodule

// File: rtl/sample_deserializer.sv
// Gathers N_SAMPLES words into a frame; send_val rises the cycle after the last word is accepted.
// Single-buffered: recv_rdy stays low while a frame waits on send_rdy.
module sample_deserializer
    import deserializer_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES-1:0]
);

    localparam int               CNT_W = cnt_width(N_SAMPLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_SAMPLES - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RECV;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Wrap by compare so non-power-of-two frame sizes never overrun the bank.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
        unique case (state_q)
            RECV: begin
                if (recv_val) begin
                    wr_en = 1'b1;
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = SEND;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            SEND: begin
                if (send_rdy) begin
                    state_d = RECV;
                end
            end
            default: begin
                state_d = RECV;
            end
        endcase
    end

    // Handshake outputs depend only on state (and reset), never on the partner's val/rdy.
    always_comb begin
        recv_rdy = 1'b0;
        send_val = 1'b0;
        if (!reset) begin
            recv_rdy = (state_q == RECV);
            send_val = (state_q == SEND);
        end
    end

    deserializer_SlotArray #(
        .BIT_WIDTH (BIT_WIDTH),
        .N_SAMPLES (N_SAMPLES),
        .CNT_W     (CNT_W)
    ) u_slots (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_idx   (count_q),
        .wr_dat   (recv_msg),
        .slot_dat (send_msg)
    );

endmodule

// File: tb/tb_sample_deserializer.sv
// Scoreboard bench for sample_deserializer (8-word and 1-word frame variants).
module tb_sample_deserializer;

    localparam int N = 8;
    typedef logic [31:0] frame_t [N];

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        recv_val = 1'b0;
    logic        recv_rdy;
    logic [31:0] recv_msg = '0;
    logic        send_val;
    logic        send_rdy = 1'b0;
    logic [31:0] send_msg [N-1:0];

    logic        rv1 = 1'b0;
    logic        rr1;
    logic [31:0] rm1 = '0;
    logic        sv1;
    logic        sr1 = 1'b0;
    logic [31:0] sm1 [0:0];

    int          n_total = 0;
    int          n_pass  = 0;

    // Reference model: frames are lists of accepted words, pending means a frame awaits pickup.
    frame_t      exp_q[$];
    frame_t      cur;
    int          cur_n   = 0;
    bit          pending = 1'b0;
    logic [31:0] q1[$];
    bit          pend1   = 1'b0;

    int          cyc       = 0;
    int          frames    = 0;
    int          frames1   = 0;
    int          last_pop  = -1;
    int          last_pop1 = -1;
    bit          streaming = 1'b0;
    int          bad;
    int          bi;
    int          f0;

    always #5 clk = ~clk;

    sample_deserializer #(.BIT_WIDTH(32), .N_SAMPLES(N)) dut (
        .clk      (clk),
        .reset    (rst),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .recv_msg (recv_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .send_msg (send_msg)
    );

    sample_deserializer #(.BIT_WIDTH(32), .N_SAMPLES(1)) dut1 (
        .clk      (clk),
        .reset    (rst),
        .recv_val (rv1),
        .recv_rdy (rr1),
        .recv_msg (rm1),
        .send_val (sv1),
        .send_rdy (sr1),
        .send_msg (sm1)
    );

    function automatic void chk(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Model update at the edge where the DUT samples its inputs.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            if (pending) void'(exp_q.pop_front());
            if (pend1) void'(q1.pop_front());
            pending = 1'b0;
            pend1   = 1'b0;
            cur_n   = 0;
        end else begin
            if (pending) begin
                if (send_rdy) pending = 1'b0;
            end else if (recv_val) begin
                cur[cur_n] = recv_msg;
                cur_n++;
                if (cur_n == N) begin
                    exp_q.push_back(cur);
                    cur_n   = 0;
                    pending = 1'b1;
                end
            end
            if (pend1) begin
                if (sr1) pend1 = 1'b0;
            end else if (rv1) begin
                q1.push_back(rm1);
                pend1 = 1'b1;
            end
        end
    end

    // Monitor for the 8-word instance.
    always @(negedge clk) begin
        chk(send_val === (!rst && pending), "send_val", 32'(send_val), 32'(!rst && pending));
        chk(recv_rdy === (!rst && !pending), "recv_rdy", 32'(recv_rdy), 32'(!rst && !pending));
        if (send_val === 1'b1 && !rst) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "frame_unexpected", 32'd1, 32'd0);
            end else begin
                bad = -1;
                for (int i = 0; i < N; i++)
                    if (bad < 0 && send_msg[i] !== exp_q[0][i]) bad = i;
                bi = (bad < 0) ? 0 : bad;
                chk(bad < 0, $sformatf("frame_word%0d", bi), send_msg[bi], exp_q[0][bi]);
                if (send_rdy) begin
                    if (streaming && last_pop >= 0)
                        chk(cyc - last_pop == N + 1, "frame_period", cyc - last_pop, N + 1);
                    last_pop = cyc;
                    frames++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Monitor for the 1-word instance.
    always @(negedge clk) begin
        chk(sv1 === (!rst && pend1), "send_val_n1", 32'(sv1), 32'(!rst && pend1));
        chk(rr1 === (!rst && !pend1), "recv_rdy_n1", 32'(rr1), 32'(!rst && !pend1));
        if (sv1 === 1'b1 && !rst) begin
            if (q1.size() == 0) begin
                chk(1'b0, "frame_unexpected_n1", 32'd1, 32'd0);
            end else begin
                chk(sm1[0] === q1[0], "frame_n1", sm1[0], q1[0]);
                if (sr1) begin
                    if (last_pop1 >= 0)
                        chk(cyc - last_pop1 == 2, "frame_period_n1", cyc - last_pop1, 2);
                    last_pop1 = cyc;
                    frames1++;
                    void'(q1.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic sr);
        recv_val = v;
        recv_msg = d;
        send_rdy = sr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) drive(1'b0, '0, 1'b0);
        rst = 1'b0;
        #2;
        for (int i = 0; i < N; i++) chk(send_msg[i] === 32'h0, "reset_msg", send_msg[i], 32'h0);

        // Basic frame, then hold under backpressure while junk is offered.
        for (int i = 0; i < N; i++) drive(1'b1, 32'h0001_0000 * (i + 1), 1'b0);
        #2;
        chk(send_msg[0] === 32'h0001_0000, "basic_first", send_msg[0], 32'h0001_0000);
        chk(send_msg[N-1] === 32'h0008_0000, "basic_last", send_msg[N-1], 32'h0008_0000);
        repeat (20) drive(1'b1, 32'hDEAD_BEEF, 1'b0);
        drive(1'b0, '0, 1'b1);

        // Gapped input with random idle stretches.
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 5)) drive(1'b0, $urandom, 1'b0);
            drive(1'b1, $urandom, 1'b0);
        end
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1);

        // Reset mid-frame discards the partial words.
        for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b0);
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) drive(1'b1, 32'hA0 + i, 1'b0);
        #2;
        for (int i = 0; i < N; i++) chk(send_msg[i] === 32'hA0 + i, "reset_mid_frame", send_msg[i], 32'hA0 + i);
        drive(1'b0, '0, 1'b1);

        // Reset while a frame is waiting drops it.
        for (int i = 0; i < N; i++) drive(1'b1, $urandom, 1'b0);
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        drive(1'b1, $urandom, 1'b1);
        rst = 1'b0;
        drive(1'b0, '0, 1'b0);

        // Streaming with both sides always ready.
        streaming = 1'b1;
        last_pop  = -1;
        f0        = frames;
        repeat (5 * (N + 1)) drive(1'b1, $urandom, 1'b1);
        streaming = 1'b0;
        drive(1'b0, '0, 1'b0);
        chk(frames - f0 == 5, "stream_frames", frames - f0, 5);

        // Single-word frames.
        for (int k = 0; k < 10; k++) begin
            rv1 = 1'b1;
            rm1 = $urandom;
            sr1 = 1'b1;
            @(posedge clk);
            #1;
        end
        rv1 = 1'b0;
        sr1 = 1'b0;
        drive(1'b0, '0, 1'b0);
        chk(frames1 == 5, "stream_frames_n1", frames1, 5);

        chk(exp_q.size() == 0, "frames_left", exp_q.size(), 0);
        chk(q1.size() == 0, "frames_left_n1", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
